// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
//   Shared definitions for the ARM-like pipeline: control-bus width, the bit
//   position of every field inside the ID/EXE control bus, the EXE command
//   encodings and the ID/EXE slot state type.
//
//   Control bus layout (9 bits, MSB first):
//     [8:5] exe_cmd  [4] mem_r_en  [3] mem_w_en  [2] wb_en  [1] b  [0] s
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int CTRL_W       = 9;
  localparam int EXE_CMD_W    = 4;

  localparam int EXE_CMD_HI   = 8;
  localparam int EXE_CMD_LO   = 5;
  localparam int MEM_R_EN_BIT = 4;
  localparam int MEM_W_EN_BIT = 3;
  localparam int WB_EN_BIT    = 2;
  localparam int B_BIT        = 1;
  localparam int S_BIT        = 0;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // EMPTY: slot holds a bubble or squashed instruction; FULL: real instruction.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // All-zero control bus: nothing is written back, no memory access, no branch.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Event counter that increments by one on each rising edge with inc=1 and
//   sticks at all-ones instead of wrapping.
//
//   Parameters: WIDTH  counter width
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset, clears count
//     inc    in   count one event this edge
//     count  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//   Pipeline register between the ID and EXE stages. Each rising edge it
//   either resets, flushes (taken branch), holds (hazard stall) or loads the
//   ID-stage values, in that priority. A load with valid_in=0 inserts a
//   bubble: the control bus is cleared while data fields still load. Two
//   saturating counters track stall cycles and flush events.
//
//   Configuration macro: ID_EXE_FORWARDING_EN adds src1/src2 register ports.
//
//   Parameters: CNT_W  width of stall_cnt / flush_cnt
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     flush, freeze                squash / hold controls
//     valid_in  -> valid_out       instruction valid
//     control_in[8:0] -> control_out {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}
//     pc, val_rn, val_rm (32)      operand values
//     imm (1), shift_operand (12), signed_imm24 (24), dest (4), status (4)
//     src1, src2 (4)               source registers, forwarding builds only
//     stall_cnt, flush_cnt (CNT_W) event counters
// ---------------------------------------------------------------------------
module id_exe_stage_reg
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       val_rn_in,
  input  logic [31:0]       val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        status_in,
`ifdef ID_EXE_FORWARDING_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
`endif
  output logic              valid_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       val_rn_out,
  output logic [31:0]       val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        status_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_state_e state, state_next;
  logic        load;

  assign load = !flush && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = SLOT_EMPTY;
    end else if (load) begin
      state_next = valid_in ? SLOT_FULL : SLOT_EMPTY;
    end
  end

  assign valid_out = (state == SLOT_FULL);

  // Flush clears every field, not just control, so a squashed slot carries
  // no stale operand that could leak into forwarding or debug views.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      control_out       <= CTRL_BUBBLE;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      status_out        <= '0;
    end else if (load) begin
      control_out       <= valid_in ? control_in : CTRL_BUBBLE;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      status_out        <= status_in;
    end
  end

`ifdef ID_EXE_FORWARDING_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      src1_out <= '0;
      src2_out <= '0;
    end else if (load) begin
      src1_out <= src1_in;
      src2_out <= src2_in;
    end
  end
`endif

  // A flush on a frozen edge counts as a flush, not as a stall cycle.
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze && !flush),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed testbench for id_exe_stage_reg. A second instance with CNT_W=4
// shares the same stimulus so counter saturation can be reached quickly.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, valid_in;
  logic [8:0]  control_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [3:0]  dest_in, status_in;

  logic        valid_out;
  logic [8:0]  control_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, status_out;
  logic [15:0] stall_cnt, flush_cnt;

  logic        valid_out4;
  logic [8:0]  control_out4;
  logic [31:0] pc_out4, val_rn_out4, val_rm_out4;
  logic        imm_out4;
  logic [11:0] shift_operand_out4;
  logic [23:0] signed_imm24_out4;
  logic [3:0]  dest_out4, status_out4;
  logic [3:0]  stall_cnt4, flush_cnt4;

`ifdef ID_EXE_FORWARDING_EN
  logic [3:0]  src1_in, src2_in, src1_out, src2_out, src1_out4, src2_out4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .control_in(control_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .status_in(status_in),
`ifdef ID_EXE_FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
`endif
    .valid_out(valid_out), .control_out(control_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .status_out(status_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .control_in(control_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .status_in(status_in),
`ifdef ID_EXE_FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out4), .src2_out(src2_out4),
`endif
    .valid_out(valid_out4), .control_out(control_out4), .pc_out(pc_out4),
    .val_rn_out(val_rn_out4), .val_rm_out(val_rm_out4), .imm_out(imm_out4),
    .shift_operand_out(shift_operand_out4), .signed_imm24_out(signed_imm24_out4),
    .dest_out(dest_out4), .status_out(status_out4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // Inputs change only here, #1 after an edge; outputs are sampled there too.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; valid_in = 1'b1;
    control_in = 9'h1FF; pc_in = 32'hDEAD; val_rn_in = 32'h1; val_rm_in = 32'h2;
    imm_in = 1'b1; shift_operand_in = 12'hFFF; signed_imm24_in = 24'h1;
    dest_in = 4'hF; status_in = 4'hF;
`ifdef ID_EXE_FORWARDING_EN
    src1_in = 4'h1; src2_in = 4'h2;
`endif
    #1;
    applyStimulus(2);
    $display("[TB] reset state");
    checkOutput("rst_control", control_out, 32'h0);
    checkOutput("rst_valid", valid_out, 32'h0);
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_dest", dest_out, 32'h0);
    checkOutput("rst_stall", stall_cnt, 32'h0);
    checkOutput("rst_flush", flush_cnt, 32'h0);

    // Load a real ADD instruction with wb_en and s set.
    rst = 1'b0;
    control_in = 9'b0010_0_0_1_0_1; pc_in = 32'h10;
    val_rn_in = 32'hAAAA_5555; val_rm_in = 32'h1234_5678; imm_in = 1'b1;
    shift_operand_in = 12'h123; signed_imm24_in = 24'hABCDEF;
    dest_in = 4'h3; status_in = 4'hA;
    applyStimulus(1);
    checkOutput("load_control", control_out, 32'h045);
    checkOutput("load_pc", pc_out, 32'h10);
    checkOutput("load_valid", valid_out, 32'h1);
    checkOutput("load_val_rn", val_rn_out, 32'hAAAA_5555);
    checkOutput("load_val_rm", val_rm_out, 32'h1234_5678);
    checkOutput("load_imm", imm_out, 32'h1);
    checkOutput("load_shift", shift_operand_out, 32'h123);
    checkOutput("load_imm24", signed_imm24_out, 32'hABCDEF);
    checkOutput("load_dest", dest_out, 32'h3);
    checkOutput("load_status", status_out, 32'hA);

    // Freeze three cycles while ID presents a new instruction.
    freeze = 1'b1; pc_in = 32'h14; control_in = 9'h1FF; dest_in = 4'h7;
    applyStimulus(3);
    checkOutput("freeze_pc", pc_out, 32'h10);
    checkOutput("freeze_control", control_out, 32'h045);
    checkOutput("freeze_dest", dest_out, 32'h3);
    checkOutput("freeze_valid", valid_out, 32'h1);
    checkOutput("freeze_stall", stall_cnt, 32'h3);

    // Flush on a frozen edge discards everything and is not a stall.
    flush = 1'b1;
    applyStimulus(1);
    checkOutput("flush_control", control_out, 32'h0);
    checkOutput("flush_valid", valid_out, 32'h0);
    checkOutput("flush_pc", pc_out, 32'h0);
    checkOutput("flush_val_rn", val_rn_out, 32'h0);
    checkOutput("flush_dest", dest_out, 32'h0);
    checkOutput("flush_cnt", flush_cnt, 32'h1);
    checkOutput("flush_stall", stall_cnt, 32'h3);

    // Bubble: invalid instruction clears control but loads data.
    flush = 1'b0; freeze = 1'b0; valid_in = 1'b0; control_in = 9'h1FF;
    pc_in = 32'h20; dest_in = 4'h9;
    applyStimulus(1);
    checkOutput("bubble_control", control_out, 32'h0);
    checkOutput("bubble_valid", valid_out, 32'h0);
    checkOutput("bubble_pc", pc_out, 32'h20);
    checkOutput("bubble_dest", dest_out, 32'h9);

    // Real instruction with every control bit set passes through intact.
    valid_in = 1'b1; pc_in = 32'h24;
    applyStimulus(1);
    checkOutput("full_control", control_out, 32'h1FF);
    checkOutput("full_valid", valid_out, 32'h1);

    // Reset asserted mid-stall once stall_cnt reaches 5.
    freeze = 1'b1; pc_in = 32'h28;
    applyStimulus(2);
    checkOutput("stall5", stall_cnt, 32'h5);
    checkOutput("stall5_pc", pc_out, 32'h24);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_control", control_out, 32'h0);
    checkOutput("midrst_valid", valid_out, 32'h0);
    checkOutput("midrst_pc", pc_out, 32'h0);
    checkOutput("midrst_status", status_out, 32'h0);
    checkOutput("midrst_stall", stall_cnt, 32'h0);
    checkOutput("midrst_flush", flush_cnt, 32'h0);

    // First edge after reset release performs a normal load.
    rst = 1'b0; freeze = 1'b0; pc_in = 32'h30; control_in = 9'b0001_0_0_1_0_0;
    applyStimulus(1);
    checkOutput("post_rst_pc", pc_out, 32'h30);
    checkOutput("post_rst_control", control_out, 32'h024);
    checkOutput("post_rst_valid", valid_out, 32'h1);

    // Hold freeze 20 cycles: the 4-bit counter saturates, the 16-bit one does not.
    freeze = 1'b1;
    applyStimulus(20);
    checkOutput("sat_stall4", stall_cnt4, 32'hF);
    checkOutput("sat_stall16", stall_cnt, 32'd20);
    checkOutput("sat_hold_pc", pc_out, 32'h30);

    // Seventeen flush edges: flush counter saturates, stall count unchanged.
    flush = 1'b1;
    applyStimulus(17);
    checkOutput("sat_flush4", flush_cnt4, 32'hF);
    checkOutput("sat_flush16", flush_cnt, 32'd17);
    checkOutput("sat_flush_stall4", stall_cnt4, 32'hF);
    checkOutput("sat_flush_stall16", stall_cnt, 32'd20);
    checkOutput("sat_flush_valid", valid_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  squash the instruction entering EXE (taken branch).
REQ-005 freeze  in  1  hold all registered outputs (hazard stall).
REQ-006 valid_in  in  1  ID holds a real instruction.
REQ-007 control_in  in  9  {exe_cmd[3:0], mem_r_en, mem_w_en, wb_en, b, s}, ID control bus.
REQ-008 pc_in  in  32; val_rn_in  in  32; val_rm_in  in  32; operand values.
REQ-009 imm_in  in  1; shift_operand_in  in  12; signed_imm24_in  in  24; dest_in  in  4; status_in  in  4 (NZCV).
REQ-010 src1_in, src2_in  in  4 each  source register numbers (present only with FORWARDING_EN).
REQ-011 Outputs: registered copies of every input in REQ-007..REQ-010, suffix _out, same widths; valid_out  out  1.
REQ-012 stall_cnt  out  CNT_W  cycles with freeze applied; flush_cnt  out  CNT_W  flush events.

Function
REQ-013 Update priority each edge SHALL be rst > flush > freeze > load.
REQ-014 Load (flush=0, freeze=0): every _out register SHALL take its _in value; valid_out SHALL take valid_in; latency exactly one cycle.
REQ-015 valid_in=0 on load: control_out SHALL be forced to 9'b0 (bubble); data fields still load.
REQ-016 Freeze (flush=0): all _out registers and valid_out SHALL hold; no input sampled.
REQ-017 Flush: control_out, valid_out, dest_out, src1_out, src2_out SHALL clear to 0; data fields (pc, val_rn, val_rm, imm, shift, imm24, status) SHALL clear to 0.
REQ-018 Flush with freeze asserted SHALL flush; the frozen instruction is discarded.
REQ-019 Squashed or bubble slot SHALL never present wb_en, mem_r_en, mem_w_en, b or s high.
REQ-020 stall_cnt SHALL increment by 1 on each edge with freeze=1 and flush=0, saturating at all-ones.
REQ-021 flush_cnt SHALL increment by 1 on each edge with flush=1, saturating at all-ones.
REQ-022 Counters SHALL not wrap; at saturation further events are ignored.
REQ-023 Register state machine: EMPTY (valid_out=0) / FULL (valid_out=1); EMPTY->FULL on load with valid_in=1; FULL->EMPTY on flush or load with valid_in=0; freeze holds state.

Reset
REQ-024 rst SHALL zero every output, both counters and valid_out on the next edge, overriding flush and freeze.
REQ-025 rst asserted mid-stall SHALL clear state; first edge after rst deassertion performs a normal load if freeze=0.

Configuration
REQ-026 Macro ID_EXE_FORWARDING_EN: when defined, src1/src2 ports and registers exist and follow REQ-014..REQ-017.
REQ-027 Without ID_EXE_FORWARDING_EN: src1/src2 ports SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 Shared package arm_pkg SHALL hold control-bus width (9), field bit positions, EXE_CMD encodings (MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001).
REQ-029 One sub-module sat_counter (parameter width, inputs clk, rst, inc; output count) SHALL be instantiated twice.

Verification
REQ-030 Load: valid_in=1, control_in=9'b0010_0_0_1_0_1, pc_in=32'h10 -> next edge control_out=9'b0010_0_0_1_0_1, pc_out=32'h10, valid_out=1.
REQ-031 Freeze 3 cycles while inputs change to pc_in=32'h14 -> pc_out stays 32'h10, stall_cnt=3.
REQ-032 flush=1 and freeze=1 same edge -> control_out=0, valid_out=0, flush_cnt=1, stall_cnt unchanged.
REQ-033 valid_in=0, control_in=9'h1FF -> control_out=9'h000, valid_out=0.
REQ-034 CNT_W=4, freeze held 20 cycles -> stall_cnt saturates at 4'hF.
REQ-035 rst=1 during freeze with stall_cnt=5 -> next edge all outputs 0, stall_cnt=0, flush_cnt=0.
